// File: rtl/poly_fir_pkg.sv
// poly_fir_pkg -- shared definitions for the polyphase FIR family
// (decimator and its interpolator sibling).
//   fir_state_e : sequencer states (IDLE / MAC / HOLD)
//   clog2()     : ceil(log2(v)), usable in parameter expressions
//   acc_w()     : accumulator width that holds the sum of ntaps full-precision
//                 products without overflow
package poly_fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // accepting samples and coefficient writes
    MAC  = 2'd1,  // walking the taps through the single multiplier
    HOLD = 2'd2   // result presented, waiting for the consumer
  } fir_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // One product needs in_w+coef_w bits; summing ntaps of them grows the
  // magnitude by at most ntaps, i.e. clog2(ntaps) extra bits.
  function automatic int acc_w(input int in_w, input int coef_w, input int ntaps);
    return in_w + coef_w + clog2(ntaps);
  endfunction

endpackage

// File: rtl/poly_fir_coef_bank.sv
// poly_fir_coef_bank -- NTAPS x COEF_W coefficient register file.
//   clk, reset : clock, synchronous active-high reset (clears every entry)
//   wr_allow   : writes are only legal while the owner is idle
//   we/addr/data : write port; a write lands on the next clock edge
//   rd_addr/rd_data : combinational read, indexed by the tap counter
//   err        : one-cycle pulse, registered, for a write that was refused
//                (not allowed right now, or addr >= NTAPS)
module poly_fir_coef_bank
  import poly_fir_pkg::*;
#(
  parameter int COEF_W = 10,
  parameter int NTAPS  = 21,
  parameter int ADDR_W = clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_allow,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [COEF_W-1:0] data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COEF_W-1:0] rd_data,
  output logic              err
);

  logic [NTAPS-1:0][COEF_W-1:0] c;
  logic                         in_range;
  logic                         wr_ok;

  // When NTAPS is not a power of two the address field can name entries
  // that do not exist; those writes are dropped and flagged.
  assign in_range = (32'(addr) < NTAPS);
  assign wr_ok    = we && wr_allow && in_range;
  assign rd_data  = c[rd_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      c   <= '0;
      err <= 1'b0;
    end else begin
      if (wr_ok) c[addr] <= data;
      err <= we && !wr_ok;
    end
  end

endmodule

// File: rtl/poly_dec_fir.sv
// poly_dec_fir -- run-time programmable decimating FIR, one shared MAC.
// Every DEC accepted samples the filter stops taking input, walks all NTAPS
// taps through one multiplier, then presents the full-precision sum until
// the consumer takes it.
//   clk, reset           : clock, synchronous active-high reset
//   x_in/x_valid/x_ready : signed sample stream in
//   y_out/y_valid/y_ready: signed ACC_W-bit result stream out
//   coef_we/coef_addr/coef_data : coefficient write port (idle only)
//   coef_err             : one-cycle pulse for a refused coefficient write
module poly_dec_fir
  import poly_fir_pkg::*;
#(
  parameter  int IN_W   = 8,
  parameter  int COEF_W = 10,
  parameter  int NTAPS  = 21,
  parameter  int DEC    = 7,
  localparam int ADDR_W = clog2(NTAPS),
  localparam int ACC_W  = acc_w(IN_W, COEF_W, NTAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IN_W-1:0]   x_in,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
  input  logic              y_ready,
  input  logic              coef_we,
  input  logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_err
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int PH_W   = (DEC > 1) ? clog2(DEC) : 1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(DEC - 1);
  localparam logic [ADDR_W-1:0] TAP_LAST = ADDR_W'(NTAPS - 1);

  fir_state_e state, state_d;

  logic                         live;       // low for the first cycle after reset
  logic [NTAPS-1:0][IN_W-1:0]   dly;        // dly[0] is the newest sample
  logic [PH_W-1:0]              phase;
  logic [ADDR_W-1:0]            tap;
  logic                         issue_done; // last tap has entered the multiplier
  logic                         prod_vld;
  logic                         prod_last;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [ACC_W-1:0]      acc;
  logic [COEF_W-1:0]            coef_rd;

  logic                         accept;
  logic                         grp_close;
  logic                         issue;
  logic                         mac_done;
  logic signed [PROD_W-1:0]     x_ext;
  logic signed [PROD_W-1:0]     c_ext;
  logic signed [PROD_W-1:0]     prod_d;
  logic signed [ACC_W-1:0]      prod_acc;
  logic signed [ACC_W-1:0]      acc_sum;

  poly_fir_coef_bank #(
    .COEF_W (COEF_W),
    .NTAPS  (NTAPS),
    .ADDR_W (ADDR_W)
  ) u_coef (
    .clk      (clk),
    .reset    (reset),
    .wr_allow (state == IDLE),
    .we       (coef_we),
    .addr     (coef_addr),
    .data     (coef_data),
    .rd_addr  (tap),
    .rd_data  (coef_rd),
    .err      (coef_err)
  );

  assign x_ready   = live && (state == IDLE);
  assign accept    = x_valid && x_ready;
  assign grp_close = accept && (phase == PH_LAST);
  assign issue     = (state == MAC) && !issue_done;
  assign mac_done  = prod_vld && prod_last;

  // Operands are sign-extended to the product width so the multiply is
  // full precision with no truncation.
  assign x_ext    = PROD_W'($signed(dly[tap]));
  assign c_ext    = PROD_W'($signed(coef_rd));
  assign prod_d   = x_ext * c_ext;
  assign prod_acc = ACC_W'(prod_q);
  assign acc_sum  = acc + prod_acc;

  // ---------------- sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grp_close) state_d = MAC;
      MAC:     if (mac_done)  state_d = HOLD;
      HOLD:    if (y_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  // The multiplier output is registered (prod_q) before the adder, so the
  // MAC runs one issue stage ahead of the accumulate stage: taps are issued
  // on NTAPS cycles and the final sum lands one cycle after the last issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      live       <= 1'b0;
      dly        <= '0;
      phase      <= '0;
      tap        <= '0;
      issue_done <= 1'b0;
      prod_vld   <= 1'b0;
      prod_last  <= 1'b0;
      prod_q     <= '0;
      acc        <= '0;
      y_out      <= '0;
      y_valid    <= 1'b0;
    end else begin
      live <= 1'b1;

      if (accept) begin
        dly <= {dly[NTAPS-2:0], x_in};
        if (grp_close) begin
          phase      <= '0;
          acc        <= '0;
          tap        <= '0;
          issue_done <= 1'b0;
        end else begin
          phase <= phase + PH_W'(1);
        end
      end

      prod_vld <= issue;
      if (issue) begin
        prod_q    <= prod_d;
        prod_last <= (tap == TAP_LAST);
        if (tap == TAP_LAST) issue_done <= 1'b1;
        else                 tap        <= tap + ADDR_W'(1);
      end

      if (prod_vld) begin
        if (prod_last) begin
          y_out   <= acc_sum;
          y_valid <= 1'b1;
        end else begin
          acc <= acc_sum;
        end
      end

      if ((state == HOLD) && y_ready) y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poly_dec_fir.sv
// tb_poly_dec_fir -- three filter instances:
//   A: NTAPS=4, DEC=2       (impulse, write protection, backpressure, reset)
//   B: COEF_W=8, NTAPS=4, DEC=1 (full-scale corner)
//   C: default 21 taps, DEC=7   (random stream, out-of-range write)
// Expected outputs come from a direct convolution over the accepted-sample
// history; a monitor per instance pops the expected queue on each handshake.
module tb_poly_dec_fir;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint fir(input int h[$], input int c[$], input int nt);
    longint s;
    int n;
    s = 0;
    n = h.size() - 1;
    for (int i = 0; i < nt; i++)
      if (n - i >= 0) s += longint'(c[i]) * longint'(h[n - i]);
    return s;
  endfunction

  // ---------------- instance A ----------------
  logic       a_rst, a_xv, a_xr, a_yv, a_yr, a_we, a_err;
  logic [7:0] a_x;
  logic [19:0] a_y;
  logic [1:0] a_addr;
  logic [9:0] a_data;
  int     a_hist[$];
  int     a_coef[$];
  longint a_exp[$];
  longint a_obs[$];
  int     a_rise[$];
  logic   a_yv_q = 1'b0;

  poly_dec_fir #(.IN_W(8), .COEF_W(10), .NTAPS(4), .DEC(2)) u_a (
    .clk(clk), .reset(a_rst), .x_in(a_x), .x_valid(a_xv), .x_ready(a_xr),
    .y_out(a_y), .y_valid(a_yv), .y_ready(a_yr), .coef_we(a_we),
    .coef_addr(a_addr), .coef_data(a_data), .coef_err(a_err));

  always @(negedge clk) begin
    if (a_yv && !a_yv_q) a_rise.push_back(cyc);
    a_yv_q = a_yv;
    if (a_yv && a_yr) begin
      a_obs.push_back(longint'($signed(a_y)));
      if (a_exp.size() == 0) chk("a_extra", a_obs.size(), 0);
      else                   chk("a_out", longint'($signed(a_y)), a_exp.pop_front());
    end
  end

  task automatic a_push(input int v);
    int n;
    n = 0;
    a_x = v[7:0]; a_xv = 1'b1;
    @(negedge clk);
    while (!a_xr && n < 100) begin @(negedge clk); n++; end
    if (!a_xr) begin chk("a_push_tmo", a_xr, 1); a_xv = 1'b0; return; end
    @(posedge clk); #1;
    a_xv = 1'b0;
    a_hist.push_back(v);
    if (a_hist.size() % 2 == 0) a_exp.push_back(fir(a_hist, a_coef, 4));
  endtask

  task automatic a_wr(input int addr, input int v, output logic err);
    a_we = 1'b1; a_addr = addr[1:0]; a_data = v[9:0];
    @(posedge clk); #1;
    a_we = 1'b0;
    err = a_err;
  endtask

  task automatic a_load(input int c0, input int c1, input int c2, input int c3);
    int   v[4];
    logic e;
    v = '{c0, c1, c2, c3};
    for (int i = 0; i < 4; i++) begin
      a_wr(i, v[i], e);
      chk("a_ld_err", e, 0);
      a_coef[i] = v[i];
    end
  endtask

  task automatic a_drain(input string tag);
    int n;
    n = 0;
    while (a_exp.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_drain"}, a_exp.size(), 0);
  endtask

  task automatic a_reset();
    a_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("a_rst_xr", a_xr, 0);
    chk("a_rst_yv", a_yv, 0);
    chk("a_rst_y", a_y, 0);
    chk("a_rst_err", a_err, 0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    a_hist.delete(); a_exp.delete(); a_rise.delete();
    a_coef = '{0, 0, 0, 0};
    @(negedge clk);
    chk("a_rdy_lag", a_xr, 0);
    @(posedge clk); #1;
    chk("a_rdy", a_xr, 1);
  endtask

  task automatic a_impulse(input string tag);
    int t2;
    t2 = 0;
    a_obs.delete(); a_rise.delete();
    for (int k = 0; k < 6; k++) begin
      a_push(k == 0 ? 1 : 0);
      if (k == 1) t2 = cyc;
    end
    a_drain(tag);
    if (a_obs.size() == 3) begin
      chk({tag, "_y0"}, a_obs[0], 2);
      chk({tag, "_y1"}, a_obs[1], 4);
      chk({tag, "_y2"}, a_obs[2], 0);
    end else chk({tag, "_cnt"}, a_obs.size(), 3);
    if (a_rise.size() > 0) chk({tag, "_lat"}, a_rise[0] - t2, 5);
    else                   chk({tag, "_rise"}, a_rise.size(), 1);
  endtask

  // ---------------- instance B ----------------
  logic        b_rst, b_xv, b_xr, b_yv, b_yr, b_we, b_err;
  logic [7:0]  b_x, b_data;
  logic [17:0] b_y;
  logic [1:0]  b_addr;
  int     b_hist[$];
  int     b_coef[$];
  longint b_exp[$];
  longint b_last = 0;
  int     b_cnt = 0;

  poly_dec_fir #(.IN_W(8), .COEF_W(8), .NTAPS(4), .DEC(1)) u_b (
    .clk(clk), .reset(b_rst), .x_in(b_x), .x_valid(b_xv), .x_ready(b_xr),
    .y_out(b_y), .y_valid(b_yv), .y_ready(b_yr), .coef_we(b_we),
    .coef_addr(b_addr), .coef_data(b_data), .coef_err(b_err));

  always @(negedge clk) begin
    if (b_yv && b_yr) begin
      b_cnt++;
      b_last = longint'($signed(b_y));
      if (b_exp.size() == 0) chk("b_extra", b_cnt, 0);
      else                   chk("b_out", b_last, b_exp.pop_front());
    end
  end

  task automatic b_push(input int v);
    int n;
    n = 0;
    b_x = v[7:0]; b_xv = 1'b1;
    @(negedge clk);
    while (!b_xr && n < 100) begin @(negedge clk); n++; end
    if (!b_xr) begin chk("b_push_tmo", b_xr, 1); b_xv = 1'b0; return; end
    @(posedge clk); #1;
    b_xv = 1'b0;
    b_hist.push_back(v);
    b_exp.push_back(fir(b_hist, b_coef, 4));
  endtask

  task automatic b_wr(input int addr, input int v, output logic err);
    b_we = 1'b1; b_addr = addr[1:0]; b_data = v[7:0];
    @(posedge clk); #1;
    b_we = 1'b0;
    err = b_err;
  endtask

  // ---------------- instance C ----------------
  logic        c_rst, c_xv, c_xr, c_yv, c_yr, c_we, c_err;
  logic [7:0]  c_x;
  logic [22:0] c_y;
  logic [4:0]  c_addr;
  logic [9:0]  c_data;
  int     c_hist[$];
  int     c_coef[$];
  longint c_exp[$];
  int     c_cnt = 0;

  poly_dec_fir u_c (
    .clk(clk), .reset(c_rst), .x_in(c_x), .x_valid(c_xv), .x_ready(c_xr),
    .y_out(c_y), .y_valid(c_yv), .y_ready(c_yr), .coef_we(c_we),
    .coef_addr(c_addr), .coef_data(c_data), .coef_err(c_err));

  always @(negedge clk) begin
    if (c_yv && c_yr) begin
      c_cnt++;
      if (c_exp.size() == 0) chk("c_extra", c_cnt, 0);
      else                   chk("c_out", longint'($signed(c_y)), c_exp.pop_front());
    end
  end

  task automatic c_push(input int v);
    int n;
    n = 0;
    c_x = v[7:0]; c_xv = 1'b1;
    @(negedge clk);
    while (!c_xr && n < 100) begin @(negedge clk); n++; end
    if (!c_xr) begin chk("c_push_tmo", c_xr, 1); c_xv = 1'b0; return; end
    @(posedge clk); #1;
    c_xv = 1'b0;
    c_hist.push_back(v);
    if (c_hist.size() % 7 == 0) c_exp.push_back(fir(c_hist, c_coef, 21));
  endtask

  task automatic c_wr(input int addr, input int v, output logic err);
    c_we = 1'b1; c_addr = addr[4:0]; c_data = v[9:0];
    @(posedge clk); #1;
    c_we = 1'b0;
    err = c_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc %0d exp 0", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic e;
    int   n;
    a_rst = 1'b1; a_xv = 1'b0; a_x = '0; a_yr = 1'b1; a_we = 1'b0; a_addr = '0; a_data = '0;
    b_rst = 1'b1; b_xv = 1'b0; b_x = '0; b_yr = 1'b1; b_we = 1'b0; b_addr = '0; b_data = '0;
    c_rst = 1'b1; c_xv = 1'b0; c_x = '0; c_yr = 1'b1; c_we = 1'b0; c_addr = '0; c_data = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("c_rst_xr", c_xr, 0);
    chk("c_rst_yv", c_yv, 0);
    chk("c_rst_y", c_y, 0);
    chk("c_rst_err", c_err, 0);
    a_reset();
    b_rst = 1'b0; c_rst = 1'b0;

    // ---- A: impulse ----
    a_load(1, 2, 3, 4);
    a_impulse("imp1");

    // ---- A: write together with the group-closing sample ----
    a_push(3);
    a_coef[2] = 11;
    a_we = 1'b1; a_addr = 2'd2; a_data = 10'd11;
    a_push(-5);
    a_we = 1'b0;

    // ---- A: write while busy is refused ----
    a_wr(1, 99, e);
    chk("a_mac_err", e, 1);
    @(posedge clk); #1;
    chk("a_err_clr", a_err, 0);
    a_drain("a_prot");

    // ---- A: legal idle write changes the next result ----
    a_wr(1, -7, e);
    chk("a_idle_err", e, 0);
    a_coef[1] = -7;
    a_push(9); a_push(-4);
    a_drain("a_new");

    // ---- A: backpressure ----
    a_yr = 1'b0;
    a_push(6); a_push(-2);
    n = 0;
    while (!a_yv && n < 50) begin @(negedge clk); n++; end
    chk("bp_wait", a_yv, 1);
    a_x = 8'd77; a_xv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_yv", a_yv, 1);
      chk("bp_y", longint'($signed(a_y)), (a_exp.size() > 0) ? a_exp[0] : 64'sd999999);
      chk("bp_xr", a_xr, 0);
    end
    a_xv = 1'b0;
    @(posedge clk); #1;
    a_yr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_rel_yv", a_yv, 0);
    chk("bp_rel_xr", a_xr, 1);
    @(posedge clk); #1;
    chk("bp_left", a_exp.size(), 0);

    // ---- A: reset at tap 2 aborts, then impulse from clean history ----
    a_push(4); a_push(8);
    repeat (2) @(posedge clk);
    #1;
    a_reset();
    a_load(1, 2, 3, 4);
    a_impulse("imp2");

    // ---- B: full-scale corner ----
    for (int i = 0; i < 4; i++) begin
      b_wr(i, -128, e);
      chk("b_ld_err", e, 0);
      b_coef.push_back(-128);
    end
    repeat (6) b_push(-128);
    n = 0;
    while (b_exp.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("b_drain", b_exp.size(), 0);
    chk("b_cnt", b_cnt, 6);
    chk("b_steady", b_last, 65536);

    // ---- C: random coefficients, out-of-range write, random stream ----
    for (int i = 0; i < 21; i++) begin
      int v;
      v = int'($urandom_range(0, 1023)) - 512;
      c_wr(i, v, e);
      chk("c_ld_err", e, 0);
      c_coef.push_back(v);
    end
    c_wr(21, 100, e);
    chk("c_oor_err", e, 1);
    @(posedge clk); #1;
    chk("c_err_clr", c_err, 0);
    for (int k = 0; k < 700; k++) begin
      c_push(int'($urandom_range(0, 255)) - 128);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    n = 0;
    while (c_exp.size() > 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("c_drain", c_exp.size(), 0);
    chk("c_cnt", c_cnt, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
